// File: rtl/bullet_pool.sv
// Fixed-slot projectile engine: accepts spawns, advances every bullet one cell per
// tick with a one-slot-per-cycle sweep, and answers tank hit probes and pixel queries.
module bullet_pool #(
  parameter int MAX_BULLETS = 16,
  parameter int COORD_W     = 10,
  parameter int FIELD_W     = 60,
  parameter int FIELD_H     = 45,
  parameter int TANK_SIZE   = 3
) (
  input  logic                               clk_100mhz,
  input  logic                               rst,
  input  logic                               tick,
  input  logic                               spawn_valid,
  output logic                               spawn_ready,
  input  logic [COORD_W-1:0]                 spawn_x,
  input  logic [COORD_W-1:0]                 spawn_y,
  input  logic [2:0]                         spawn_dir,
  input  logic                               spawn_owner,
  input  logic [COORD_W-1:0]                 player_x,
  input  logic [COORD_W-1:0]                 player_y,
  output logic                               player_hit,
  input  logic                               probe_valid,
  output logic                               probe_ready,
  input  logic [COORD_W-1:0]                 probe_x,
  input  logic [COORD_W-1:0]                 probe_y,
  output logic                               probe_done,
  output logic                               probe_hit,
  input  logic [COORD_W-1:0]                 pix_x,
  input  logic [COORD_W-1:0]                 pix_y,
  output logic                               pix_bullet,
  output logic [$clog2(MAX_BULLETS+1)-1:0]   n_active,
  output logic                               busy
);

  localparam int IDX_W = $clog2(MAX_BULLETS);
  localparam int CNT_W = $clog2(MAX_BULLETS + 1);
  localparam int BW    = COORD_W + 1;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MAX_BULLETS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(FIELD_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(FIELD_H - 1);
  localparam logic [COORD_W-1:0] X_LIMIT  = COORD_W'(FIELD_W);
  localparam logic [COORD_W-1:0] Y_LIMIT  = COORD_W'(FIELD_H);
  localparam logic [COORD_W-1:0] C_ZERO   = '0;
  localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);
  localparam logic [BW-1:0]      BOX      = BW'(TANK_SIZE);

  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [2:0] DIR_UP    = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b011;

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  state_t state, next_state;
  logic [IDX_W-1:0] idx;

  logic [MAX_BULLETS-1:0] slot_valid;
  logic [MAX_BULLETS-1:0] slot_owner;
  logic [COORD_W-1:0]     slot_x   [MAX_BULLETS];
  logic [COORD_W-1:0]     slot_y   [MAX_BULLETS];
  logic [2:0]             slot_dir [MAX_BULLETS];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             match_found;
  logic [IDX_W-1:0] match_idx;
  logic             spawn_fire;
  logic             spawn_keep;
  logic             probe_fire;

  logic               cur_valid;
  logic               cur_owner;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic [2:0]         cur_dir;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               step_free;
  logic               step_hit;

  logic             pix_match;
  logic [CNT_W-1:0] valid_count;

  // Box compares are done one bit wider so that corner + TANK_SIZE cannot wrap.
  function automatic logic in_box(input logic [COORD_W-1:0] px,
                                  input logic [COORD_W-1:0] py,
                                  input logic [COORD_W-1:0] bx,
                                  input logic [COORD_W-1:0] by);
    logic [BW-1:0] ex, ey, lx, ly;
    ex = {1'b0, px};
    ey = {1'b0, py};
    lx = {1'b0, bx};
    ly = {1'b0, by};
    return (ex >= lx) && (ex < lx + BOX) && (ey >= ly) && (ey < ly + BOX);
  endfunction

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= (state == SWEEP && idx != LAST_IDX) ? idx + IDX_ONE : '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tick) next_state = SWEEP;
      SWEEP:   if (idx == LAST_IDX) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == SWEEP);
    spawn_ready = ~rst & (state == IDLE) & free_found;
    probe_ready = ~rst & (state == IDLE) & ~tick;
    player_hit  = (state == SWEEP) & step_hit;
  end

  assign spawn_fire = spawn_valid & spawn_ready;
  assign spawn_keep = (spawn_x < X_LIMIT) && (spawn_y < Y_LIMIT);
  assign probe_fire = probe_valid & probe_ready;

  // Scanning downwards leaves the lowest qualifying index in the result.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (slot_valid[i] && slot_owner[i] &&
          in_box(slot_x[i], slot_y[i], probe_x, probe_y)) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end
  end

  assign cur_valid = slot_valid[idx];
  assign cur_owner = slot_owner[idx];
  assign cur_x     = slot_x[idx];
  assign cur_y     = slot_y[idx];
  assign cur_dir   = slot_dir[idx];

  // Boundary checks come before the step so coordinates never wrap.
  always_comb begin
    step_free = 1'b0;
    next_x    = cur_x;
    next_y    = cur_y;
    case (cur_dir)
      DIR_LEFT:  if (cur_x == C_ZERO) step_free = 1'b1; else next_x = cur_x - C_ONE;
      DIR_RIGHT: if (cur_x == X_LAST) step_free = 1'b1; else next_x = cur_x + C_ONE;
      DIR_UP:    if (cur_y == C_ZERO) step_free = 1'b1; else next_y = cur_y - C_ONE;
      DIR_DOWN:  if (cur_y == Y_LAST) step_free = 1'b1; else next_y = cur_y + C_ONE;
      default:   step_free = 1'b1;
    endcase
    step_hit = cur_valid & ~step_free & ~cur_owner &
               in_box(next_x, next_y, player_x, player_y);
  end

  // Spawn and probe act only in IDLE and touch disjoint slots; the sweep owns SWEEP.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      slot_owner <= '0;
      for (int i = 0; i < MAX_BULLETS; i++) begin
        slot_x[i]   <= '0;
        slot_y[i]   <= '0;
        slot_dir[i] <= '0;
      end
    end else begin
      if (probe_fire && match_found) begin
        slot_valid[match_idx] <= 1'b0;
      end
      if (spawn_fire && spawn_keep) begin
        slot_valid[free_idx] <= 1'b1;
        slot_owner[free_idx] <= spawn_owner;
        slot_x[free_idx]     <= spawn_x;
        slot_y[free_idx]     <= spawn_y;
        slot_dir[free_idx]   <= spawn_dir;
      end
      if (state == SWEEP && cur_valid) begin
        if (step_free || step_hit) begin
          slot_valid[idx] <= 1'b0;
        end else begin
          slot_x[idx] <= next_x;
          slot_y[idx] <= next_y;
        end
      end
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      probe_done <= 1'b0;
      probe_hit  <= 1'b0;
    end else begin
      probe_done <= probe_fire;
      probe_hit  <= probe_fire & match_found;
    end
  end

  always_comb begin
    pix_match   = 1'b0;
    valid_count = '0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (slot_valid[i] && slot_x[i] == pix_x && slot_y[i] == pix_y) pix_match = 1'b1;
      valid_count = valid_count + CNT_W'(slot_valid[i]);
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      pix_bullet <= 1'b0;
      n_active   <= '0;
    end else begin
      pix_bullet <= pix_match;
      n_active   <= valid_count;
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed self-checking bench for bullet_pool: movement, frees, hits, full pool,
// probe consumption order and reset during a sweep.
module tb_bullet_pool;

  logic       clk_100mhz;
  logic       rst;
  logic       tick;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic [2:0] spawn_dir;
  logic       spawn_owner;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       player_hit;
  logic       probe_valid;
  logic       probe_ready;
  logic [9:0] probe_x;
  logic [9:0] probe_y;
  logic       probe_done;
  logic       probe_hit;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_bullet;
  logic [4:0] n_active;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int   busy_cycles;
  int   hit_count;
  int   ready_during;
  logic ready_after;

  bullet_pool dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .tick       (tick),
    .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .spawn_dir  (spawn_dir),
    .spawn_owner(spawn_owner),
    .player_x   (player_x),
    .player_y   (player_y),
    .player_hit (player_hit),
    .probe_valid(probe_valid),
    .probe_ready(probe_ready),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .probe_done (probe_done),
    .probe_hit  (probe_hit),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_bullet (pix_bullet),
    .n_active   (n_active),
    .busy       (busy)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  // Tasks start and end one time unit after a rising edge.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    idle(1);
    @(negedge clk_100mhz);
    check_output({tag, "_spawn_ready"}, spawn_ready, 0);
    check_output({tag, "_probe_ready"}, probe_ready, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_n_active"}, n_active, 0);
    check_output({tag, "_pix_bullet"}, pix_bullet, 0);
    check_output({tag, "_probe_done"}, probe_done, 0);
    check_output({tag, "_player_hit"}, player_hit, 0);
    idle(1);
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [9:0] x, input logic [9:0] y,
                                input logic [2:0] dir, input logic owner);
    logic ok;
    ok = 1'b0;
    spawn_x = x; spawn_y = y; spawn_dir = dir; spawn_owner = owner;
    spawn_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_100mhz);
      if (spawn_ready) begin
        ok = 1'b1;
        break;
      end
    end
    idle(1);
    spawn_valid = 1'b0;
    if (!ok) check_output("spawn_accept_timeout", ok, 1);
  endtask

  task automatic run_sweep();
    tick = 1'b1;
    idle(1);
    tick = 1'b0;
    busy_cycles = 0; hit_count = 0; ready_during = 0; ready_after = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_100mhz);
      if (!busy) begin
        ready_after = spawn_ready;
        break;
      end
      busy_cycles++;
      hit_count    += int'(player_hit);
      ready_during += int'(spawn_ready);
    end
    idle(1);
  endtask

  task automatic query_pix(input logic [9:0] x, input logic [9:0] y,
                           input logic expected, input string tag);
    pix_x = x; pix_y = y;
    idle(1);
    @(negedge clk_100mhz);
    check_output(tag, pix_bullet, expected);
    idle(1);
  endtask

  task automatic do_probe(input logic [9:0] x, input logic [9:0] y,
                          input logic exp_hit, input string tag);
    logic ok;
    ok = 1'b0;
    probe_x = x; probe_y = y; probe_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_100mhz);
      if (probe_ready) begin
        ok = 1'b1;
        break;
      end
    end
    idle(1);
    probe_valid = 1'b0;
    check_output({tag, "_accepted"}, ok, 1);
    @(negedge clk_100mhz);
    check_output({tag, "_done"}, probe_done, 1);
    check_output({tag, "_hit"}, probe_hit, exp_hit);
    idle(1);
    @(negedge clk_100mhz);
    check_output({tag, "_done_pulse"}, probe_done, 0);
    idle(1);
  endtask

  task automatic check_count(input int expected, input string tag);
    idle(1);
    @(negedge clk_100mhz);
    check_output(tag, n_active, expected);
    idle(1);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0;
    spawn_valid = 1'b0; spawn_x = '0; spawn_y = '0; spawn_dir = '0; spawn_owner = 1'b0;
    player_x = 10'd50; player_y = 10'd40;
    probe_valid = 1'b0; probe_x = '0; probe_y = '0;
    pix_x = '0; pix_y = '0;
    $display("[TB] start");

    // Player bullet moving right for three ticks
    apply_reset("rst1");
    apply_stimulus(10'd5, 10'd5, 3'b001, 1'b1);
    run_sweep();
    check_output("sweep_busy_cycles", busy_cycles, 16);
    run_sweep();
    run_sweep();
    check_output("move_n_active", n_active, 1);
    query_pix(10'd8, 10'd5, 1'b1, "move_pix_at_8_5");
    query_pix(10'd7, 10'd5, 1'b0, "move_pix_at_7_5");

    // Edge frees, out-of-field discards and dir 1xx
    apply_reset("rst2");
    player_x = 10'd0; player_y = 10'd9;
    apply_stimulus(10'd0, 10'd10, 3'b000, 1'b0);
    apply_stimulus(10'd59, 10'd3, 3'b001, 1'b1);
    apply_stimulus(10'd58, 10'd3, 3'b001, 1'b1);
    apply_stimulus(10'd30, 10'd30, 3'b100, 1'b1);
    apply_stimulus(10'd60, 10'd5, 3'b001, 1'b1);
    apply_stimulus(10'd5, 10'd45, 3'b010, 1'b1);
    check_count(4, "edge_n_active_before");
    run_sweep();
    check_output("edge_player_hit", hit_count, 0);
    check_count(1, "edge_n_active_after");
    query_pix(10'd59, 10'd3, 1'b1, "edge_pix_at_59_3");

    // Enemy bullet steps into the player tank
    apply_reset("rst3");
    player_x = 10'd9; player_y = 10'd21;
    apply_stimulus(10'd10, 10'd20, 3'b011, 1'b0);
    run_sweep();
    check_output("hit_pulses", hit_count, 1);
    check_count(0, "hit_n_active");
    query_pix(10'd10, 10'd21, 1'b0, "hit_pix_at_10_21");
    player_x = 10'd50; player_y = 10'd40;

    // Full pool: the 17th request waits for the sweep to free slot 3
    apply_reset("rst4");
    for (int i = 0; i < 16; i++) begin
      if (i == 3) apply_stimulus(10'd0, 10'd30, 3'b000, 1'b1);
      else        apply_stimulus(10'd10, 10'(i), 3'b001, 1'b1);
    end
    check_count(16, "full_n_active");
    spawn_x = 10'd30; spawn_y = 10'd40; spawn_dir = 3'b001; spawn_owner = 1'b1;
    spawn_valid = 1'b1;
    @(negedge clk_100mhz);
    check_output("full_spawn_ready", spawn_ready, 0);
    idle(1);
    run_sweep();
    spawn_valid = 1'b0;
    check_output("full_busy_cycles", busy_cycles, 16);
    check_output("full_ready_during_sweep", ready_during, 0);
    check_output("full_ready_after_sweep", ready_after, 1);
    @(negedge clk_100mhz);
    check_output("full_ready_refilled", spawn_ready, 0);
    check_count(16, "full_n_active_refilled");
    query_pix(10'd30, 10'd40, 1'b1, "full_pix_new_bullet");
    query_pix(10'd11, 10'd4, 1'b1, "full_pix_slot4");

    // Probe consumes the lowest matching player bullet, one per probe
    apply_reset("rst5");
    apply_stimulus(10'd5, 10'd5, 3'b001, 1'b1);
    apply_stimulus(10'd6, 10'd6, 3'b001, 1'b1);
    apply_stimulus(10'd20, 10'd20, 3'b001, 1'b1);
    apply_stimulus(10'd21, 10'd21, 3'b001, 1'b0);
    apply_stimulus(10'd40, 10'd40, 3'b001, 1'b1);
    apply_stimulus(10'd22, 10'd22, 3'b000, 1'b1);
    do_probe(10'd20, 10'd20, 1'b1, "probe1");
    query_pix(10'd20, 10'd20, 1'b0, "probe1_slot2_freed");
    query_pix(10'd22, 10'd22, 1'b1, "probe1_slot5_kept");
    do_probe(10'd20, 10'd20, 1'b1, "probe2");
    query_pix(10'd22, 10'd22, 1'b0, "probe2_slot5_freed");
    do_probe(10'd20, 10'd20, 1'b0, "probe3");
    query_pix(10'd21, 10'd21, 1'b1, "probe_enemy_kept");
    check_count(4, "probe_n_active");

    // Reset while the sweep is on slot 7
    apply_reset("rst6");
    apply_stimulus(10'd5, 10'd5, 3'b001, 1'b1);
    apply_stimulus(10'd6, 10'd6, 3'b011, 1'b1);
    apply_stimulus(10'd7, 10'd7, 3'b010, 1'b0);
    tick = 1'b1;
    idle(1);
    tick = 1'b0;
    idle(7);
    @(negedge clk_100mhz);
    check_output("midsweep_busy_before", busy, 1);
    rst = 1'b1;
    idle(1);
    @(negedge clk_100mhz);
    check_output("midsweep_busy_after_rst", busy, 0);
    check_output("midsweep_n_active_after_rst", n_active, 0);
    idle(1);
    rst = 1'b0;
    run_sweep();
    check_output("post_rst_busy_cycles", busy_cycles, 16);
    check_output("post_rst_hits", hit_count, 0);
    check_count(0, "post_rst_n_active");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
